// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush,
// downstream hold and a saturating count of load-use stall cycles.
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  id_pc4,
  input  logic [ADDR_W-1:0]  id_rs,
  input  logic [ADDR_W-1:0]  id_rt,
  input  logic [ADDR_W-1:0]  id_rd,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_uses_rt,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               id_alu_src,
  input  logic               id_reg_dst,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               flush,
  input  logic               hold,
  output logic [DATA_W-1:0]  ex_pc4,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [ADDR_W-1:0]  ex_rs,
  output logic [ADDR_W-1:0]  ex_rt,
  output logic [ADDR_W-1:0]  ex_wr_addr,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_valid,
  output logic               pc_write_en,
  output logic               ifid_write_en,
  output logic               load_use_stall,
  output logic [CNT_W-1:0]   stall_count
);

  // Flow control: ex_valid=1 marks a real instruction in EX. The stage
  // advances on every edge unless hold=1; pc_write_en/ifid_write_en=1 tell
  // upstream its decode instruction was consumed this edge.
  logic              hz;
  logic              bubble;
  logic [ADDR_W-1:0] id_wr_addr;

  always_comb begin
    hz = 1'b0;
    if (ex_valid && ex_mem_read && (ex_wr_addr != '0)) begin
      hz = (ex_wr_addr == id_rs) || (id_uses_rt && (ex_wr_addr == id_rt));
    end
  end

  assign load_use_stall = hz & ~flush & ~hold;
  assign pc_write_en    = ~hold & ~load_use_stall;
  assign ifid_write_en  = ~hold & ~load_use_stall;
  assign bubble         = flush | load_use_stall;
  assign id_wr_addr     = id_reg_dst ? id_rd : id_rt;

  // Bubbles clear data and address fields too, keeping EX deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc4        <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_wr_addr    <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= '0;
      ex_valid      <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        ex_pc4        <= '0;
        ex_rs_data    <= '0;
        ex_rt_data    <= '0;
        ex_imm        <= '0;
        ex_rs         <= '0;
        ex_rt         <= '0;
        ex_wr_addr    <= '0;
        ex_reg_write  <= 1'b0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_alu_src    <= 1'b0;
        ex_alu_op     <= '0;
        ex_valid      <= 1'b0;
      end else begin
        ex_pc4        <= id_pc4;
        ex_rs_data    <= id_rs_data;
        ex_rt_data    <= id_rt_data;
        ex_imm        <= id_imm;
        ex_rs         <= id_rs;
        ex_rt         <= id_rt;
        ex_wr_addr    <= id_wr_addr;
        ex_reg_write  <= id_reg_write;
        ex_mem_read   <= id_mem_read;
        ex_mem_write  <= id_mem_write;
        ex_mem_to_reg <= id_mem_to_reg;
        ex_alu_src    <= id_alu_src;
        ex_alu_op     <= id_alu_op;
        ex_valid      <= 1'b1;
      end
    end
  end

  // load_use_stall already excludes hold, so the counter needs no extra gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (load_use_stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage: a reference model predicts
// the EX slot each cycle, and a monitor compares it against the DUT.
module tb_id_ex_stage;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int EX_W    = 4 * DATA_W + 3 * ADDR_W + 5 + ALUOP_W + 1;
  localparam int OUT_W   = EX_W + CNT_W;

  logic               clk, rst_n;
  logic [DATA_W-1:0]  id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [ADDR_W-1:0]  id_rs, id_rt, id_rd;
  logic               id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
  logic               id_mem_to_reg, id_alu_src, id_reg_dst;
  logic [ALUOP_W-1:0] id_alu_op;
  logic               flush, hold;
  logic [DATA_W-1:0]  ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [ADDR_W-1:0]  ex_rs, ex_rt, ex_wr_addr;
  logic               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic               ex_valid, pc_write_en, ifid_write_en, load_use_stall;
  logic [CNT_W-1:0]   stall_count;

  typedef struct packed {
    logic [DATA_W-1:0]  pc4;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [DATA_W-1:0]  imm;
    logic [ADDR_W-1:0]  rs;
    logic [ADDR_W-1:0]  rt;
    logic [ADDR_W-1:0]  wr_addr;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               valid;
  } ex_t;

  typedef struct packed {
    logic [DATA_W-1:0]  pc4;
    logic [ADDR_W-1:0]  rs;
    logic [ADDR_W-1:0]  rt;
    logic [ADDR_W-1:0]  rd;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [DATA_W-1:0]  imm;
    logic               uses_rt;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic               reg_dst;
    logic [ALUOP_W-1:0] alu_op;
    logic               flush;
    logic               hold;
  } id_t;

  ex_t              m_ex;
  logic [CNT_W-1:0] m_cnt;
  logic [OUT_W-1:0] exp_q[$];
  int               checks = 0;
  int               failures = 0;

  id_ex_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op), .flush(flush), .hold(hold),
    .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wr_addr(ex_wr_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_valid(ex_valid), .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .load_use_stall(load_use_stall), .stall_count(stall_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] dut_out();
    return {ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_wr_addr,
            ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
            ex_alu_op, ex_valid, stall_count};
  endfunction

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input id_t t);
    id_pc4 = t.pc4;         id_rs = t.rs;               id_rt = t.rt;
    id_rd = t.rd;           id_rs_data = t.rs_data;     id_rt_data = t.rt_data;
    id_imm = t.imm;         id_uses_rt = t.uses_rt;     id_reg_write = t.reg_write;
    id_mem_read = t.mem_read; id_mem_write = t.mem_write; id_mem_to_reg = t.mem_to_reg;
    id_alu_src = t.alu_src; id_reg_dst = t.reg_dst;     id_alu_op = t.alu_op;
    flush = t.flush;        hold = t.hold;
  endtask

  // One decode slot: drive, check the combinational controls, predict the edge.
  task automatic step(input id_t t);
    logic hz, stall, adv;
    @(negedge clk);
    #1 drive(t);
    #1;
    hz = m_ex.valid && m_ex.mem_read && (m_ex.wr_addr != 0) &&
         ((m_ex.wr_addr == t.rs) || (t.uses_rt && (m_ex.wr_addr == t.rt)));
    stall = hz && !t.flush && !t.hold;
    adv = !t.hold && !stall;
    check("comb_stall_pcw_ifidw", OUT_W'({load_use_stall, pc_write_en, ifid_write_en}),
          OUT_W'({stall, adv, adv}));
    if (!t.hold) begin
      if (t.flush || stall) begin
        m_ex = '0;
        if (stall && (int'(m_cnt) < CNT_MAX)) m_cnt = m_cnt + 1'b1;
      end else begin
        m_ex.pc4 = t.pc4;           m_ex.rs_data = t.rs_data;   m_ex.rt_data = t.rt_data;
        m_ex.imm = t.imm;           m_ex.rs = t.rs;             m_ex.rt = t.rt;
        m_ex.wr_addr = t.reg_dst ? t.rd : t.rt;
        m_ex.reg_write = t.reg_write; m_ex.mem_read = t.mem_read; m_ex.mem_write = t.mem_write;
        m_ex.mem_to_reg = t.mem_to_reg; m_ex.alu_src = t.alu_src; m_ex.alu_op = t.alu_op;
        m_ex.valid = 1'b1;
      end
    end
    exp_q.push_back({m_ex, m_cnt});
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_immediate", dut_out(), '0);
    m_ex = '0;
    m_cnt = '0;
    @(posedge clk);
    #1 check("reset_held_over_edge", dut_out(), '0);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic id_t lw(input logic [ADDR_W-1:0] dst);
    id_t t = '0;
    t.pc4 = 32'h0000_0104; t.rs = 5'd2; t.rt = dst; t.imm = 32'h0000_0010;
    t.mem_read = 1'b1; t.reg_write = 1'b1; t.mem_to_reg = 1'b1; t.alu_src = 1'b1;
    t.alu_op = 4'h2;
    return t;
  endfunction

  function automatic id_t add(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] t2);
    id_t t = '0;
    t.pc4 = 32'h0000_0108; t.rs = s; t.rt = t2; t.rd = 5'd10; t.uses_rt = 1'b1;
    t.reg_dst = 1'b1; t.reg_write = 1'b1; t.alu_op = 4'h2;
    t.rs_data = 32'hA5A5_0001; t.rt_data = 32'h5A5A_0002;
    return t;
  endfunction

  function automatic id_t rand_id();
    id_t t;
    t.pc4 = $urandom;       t.rs_data = $urandom;   t.rt_data = $urandom;  t.imm = $urandom;
    t.rs = ADDR_W'($urandom_range(0, 3));
    t.rt = ADDR_W'($urandom_range(0, 3));
    t.rd = ADDR_W'($urandom_range(0, 31));
    t.uses_rt = 1'($urandom_range(0, 1));
    t.reg_write = 1'($urandom_range(0, 1));
    t.mem_read = 1'($urandom_range(0, 1));
    t.mem_write = 1'($urandom_range(0, 1));
    t.mem_to_reg = 1'($urandom_range(0, 1));
    t.alu_src = 1'($urandom_range(0, 1));
    t.reg_dst = 1'($urandom_range(0, 1));
    t.alu_op = ALUOP_W'($urandom_range(0, 15));
    t.flush = ($urandom_range(0, 9) == 0);
    t.hold = ($urandom_range(0, 9) == 0);
    return t;
  endfunction

  // Scoreboard monitor: one prediction per edge, compared on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (exp_q.size() > 0)) check("ex_regs", dut_out(), exp_q.pop_front());
    end
  end

  initial begin
    id_t t;
    rst_n = 1'b0;
    drive('0);
    m_ex = '0;
    m_cnt = '0;
    #12 check("reset_state", dut_out(), '0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Normal capture with rd-selected destination
    t = '0;
    t.rs_data = 32'h1234_5678; t.imm = 32'hFFFF_FFFC; t.reg_dst = 1'b1;
    t.rd = 5'd9; t.rt = 5'd3; t.pc4 = 32'h0000_0100; t.reg_write = 1'b1;
    step(t);
    step(lw(5'd8));
    reset_mid_cycle();

    // Load-use: stall once, then the add is taken
    step(lw(5'd8));
    step(add(5'd8, 5'd4));
    step(add(5'd8, 5'd4));
    // lw to $0 never hazards
    step(lw(5'd0));
    step(add(5'd0, 5'd0));
    // rt match ignored when rt is not a source
    step(lw(5'd8));
    t = add(5'd1, 5'd8);
    t.uses_rt = 1'b0;
    step(t);
    // Flush beats the hazard
    step(lw(5'd8));
    t = add(5'd8, 5'd8);
    t.flush = 1'b1;
    step(t);
    // Hold for three cycles with a live hazard and changing inputs
    step(lw(5'd8));
    for (int i = 0; i < 3; i++) begin
      t = rand_id();
      t.rs = 5'd8;
      t.hold = 1'b1;
      step(t);
    end
    step(add(5'd8, 5'd1));
    step(add(5'd8, 5'd1));

    // Drive the stall counter to saturation and beyond
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      step(lw(5'd8));
      step(add(5'd8, 5'd8));
    end

    for (int i = 0; i < 3000; i++) step(rand_id());
    reset_mid_cycle();
    for (int i = 0; i < 200; i++) step(rand_id());

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", OUT_W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register. It sits directly downstream of the register file.
- Captures the RegFile read data (R1out/R2out), the decoded fields and the control bits, then presents them to the EX stage one cycle later.
- Contains load-use hazard detection. A detected hazard stalls PC/IF-ID and inserts a bubble.
- Handles branch flush, external pipeline hold, and a saturating stall-cycle counter.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 5, register address width
ALUOP_W, 4, ALU operation code width
CNT_W, 16, stall counter width

Ports:
clk  input  1  pipeline clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
id_pc4  input  DATA_W  PC+4 of decode instruction
id_rs  input  ADDR_W  rs field (RegFile R1addr)
id_rt  input  ADDR_W  rt field (RegFile R2addr)
id_rd  input  ADDR_W  rd field
id_rs_data  input  DATA_W  RegFile R1out
id_rt_data  input  DATA_W  RegFile R2out
id_imm  input  DATA_W  sign-extended immediate
id_uses_rt  input  1  instruction reads rt as a source
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  input  1 each  decode controls
id_alu_op  input  ALUOP_W  ALU operation
flush  input  1  branch/jump taken: kill decode instruction
hold  input  1  downstream stall: freeze the stage
ex_pc4, ex_rs_data, ex_rt_data, ex_imm  output  DATA_W  registered operands
ex_rs, ex_rt  output  ADDR_W  registered source addresses, for forwarding
ex_wr_addr  output  ADDR_W  registered destination: id_reg_dst ? id_rd : id_rt
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  output  1  registered controls
ex_alu_op  output  ALUOP_W  registered ALU op
ex_valid  output  1  EX slot holds a real instruction
pc_write_en  output  1  combinational; PC may update
ifid_write_en  output  1  combinational; IF/ID register may update
load_use_stall  output  1  combinational hazard indication
stall_count  output  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (rst_n=0, asynchronous): all ex_* outputs = 0, ex_valid = 0, stall_count = 0. Reset takes effect immediately and overrides any event in flight. A flushed or stalled instruction is simply lost.
- Hazard condition, combinational:
  - hz = ex_valid & ex_mem_read & (ex_wr_addr != 0) & ((ex_wr_addr == id_rs) | (id_uses_rt & ex_wr_addr == id_rt)).
  - load_use_stall = hz & !flush & !hold.
- Rising-edge update, by priority:
  1. hold=1: every register keeps its value. pc_write_en = 0, ifid_write_en = 0. stall_count unchanged.
  2. flush=1: bubble loaded. pc_write_en = 1, ifid_write_en = 1. Any hazard is ignored.
  3. load_use_stall=1: bubble loaded. pc_write_en = 0, ifid_write_en = 0. stall_count increments, saturating at all-ones.
  4. Otherwise: all id_* values are captured. ex_valid = 1, ex_wr_addr = mux result. pc_write_en = 1, ifid_write_en = 1.
- Bubble definition: ex_valid = 0 and all ex_* control bits, ex_alu_op and ex_wr_addr = 0. Data and address fields are also forced to 0 so bubbles are deterministic.
- Latency: exactly 1 cycle from id_* to ex_*, with no combinational path from id_* to ex_*. pc_write_en, ifid_write_en and load_use_stall are combinational from the current registers and the inputs.
- A stall lasts exactly one cycle. The next cycle holds the bubble, so ex_valid=0 and hz=0 without further logic.
- Register $0: a destination of 0 never raises a hazard. Writes to $0 pass through unchanged; the RegFile discards them.
- A load with ex_reg_dst-selected rd is still checked through ex_wr_addr.
- Back-to-back loads where the second depends on the first: a single stall is raised, then normal flow resumes.
- Simultaneous flush and hold: hold wins, and flush must be held by its source until hold drops.

Test Plan:
- Reset: set rst_n=0 mid-cycle with ex_valid=1 -> all ex_* = 0, ex_valid = 0 and stall_count = 0 immediately, without waiting for a clk edge.
- Normal capture: id_rs_data=32'h1234_5678, id_imm=32'hFFFF_FFFC, id_reg_dst=1, id_rd=9 -> next cycle ex_rs_data=32'h1234_5678, ex_imm=32'hFFFF_FFFC, ex_wr_addr=9, ex_valid=1.
- Load-use hazard:
  - Stimulus: lw to $8 in EX (mem_read=1, wr_addr=8), then decode add rs=8.
  - Required: load_use_stall=1, pc_write_en=0, ifid_write_en=0 for one cycle.
  - Required: next cycle ex_valid=0, stall_count=1; the following cycle the add is captured with ex_valid=1.
- No hazard cases:
  - lw to $0 in EX with id_rs=0 -> load_use_stall=0.
  - lw to $8 with id_rt=8 and id_uses_rt=0 -> load_use_stall=0.
- Flush beats hazard: hazard condition true and flush=1 -> load_use_stall=0, pc_write_en=1, bubble in EX, stall_count unchanged.
- Hold and saturation:
  - hold=1 for 3 cycles while id_* changes -> ex_* stays constant and pc_write_en=0 throughout.
  - Force stall_count to all-ones via repeated hazards -> stays 16'hFFFF.
